// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage.
//   OP_NOP        opcode value that the decoder uses for "no instruction"
//   ROB_TAG_NONE  ROB tag meaning "operand has no producer" (real tags are 1..2^ROB_W-1)
//   DEF_*         default widths used by the interface and the top module
//   opcode_t      opcode type at the default width
//   entry_t       queued instruction at the default widths
// The top module redeclares the entry layout from its own parameters, so non-default widths work.
package dispatch_stage_pkg;

  localparam int unsigned DEF_ID_W   = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_REG_W  = 5;
  localparam int unsigned DEF_ROB_W  = 4;
  localparam int unsigned DEF_OP_W   = 6;

  typedef logic [DEF_OP_W-1:0] opcode_t;

  localparam opcode_t                OP_NOP       = '0;
  localparam logic [DEF_ROB_W-1:0]   ROB_TAG_NONE = '0;

  typedef struct packed {
    logic [DEF_REG_W-1:0]  rs;
    logic [DEF_REG_W-1:0]  rt;
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_ID_W-1:0]   imm;
    opcode_t               op;
    logic [DEF_ADDR_W-1:0] pc;
    logic                  taken;
  } entry_t;

endpackage

// File: rtl/dispatch_stage_if.sv
// Bundle of every non-clock signal of the dispatch stage.
//   slave  modport: the dispatch stage itself (decoder/regfile/ROB/RS/CDB inputs, issue outputs)
//   master modport: the surrounding pipeline (decoder, regfile, ROB, RS, CDB)
// Signal names keep the _in/_out suffixes as seen from the dispatch stage.
interface dispatch_stage_if
  import dispatch_stage_pkg::*;
#(
  parameter int unsigned ID_W   = DEF_ID_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned ROB_W  = DEF_ROB_W,
  parameter int unsigned OP_W   = DEF_OP_W
);

  logic              rdy_in;
  logic              clear_in;

  // Decoder
  logic              dec_valid_in;
  logic              dec_ready_out;
  logic [REG_W-1:0]  dec_rs_in;
  logic [REG_W-1:0]  dec_rt_in;
  logic [REG_W-1:0]  dec_rd_in;
  logic [ID_W-1:0]   dec_imm_in;
  logic [OP_W-1:0]   dec_op_in;
  logic [ADDR_W-1:0] dec_pc_in;
  logic              dec_taken_in;

  // Register file
  logic [REG_W-1:0]  rf_rs_out;
  logic [REG_W-1:0]  rf_rt_out;
  logic              rf_rs_busy_in;
  logic              rf_rt_busy_in;
  logic [ID_W-1:0]   rf_rs_val_in;
  logic [ID_W-1:0]   rf_rt_val_in;
  logic [ROB_W-1:0]  rf_rs_tag_in;
  logic [ROB_W-1:0]  rf_rt_tag_in;
  logic              rf_rd_en_out;
  logic [REG_W-1:0]  rf_rd_out;
  logic [ROB_W-1:0]  rf_tag_out;

  // Reorder buffer
  logic [ROB_W-1:0]  rob_rs_h_out;
  logic [ROB_W-1:0]  rob_rt_h_out;
  logic              rob_rs_ready_in;
  logic              rob_rt_ready_in;
  logic [ID_W-1:0]   rob_rs_val_in;
  logic [ID_W-1:0]   rob_rt_val_in;
  logic              rob_full_in;
  logic [ROB_W-1:0]  rob_b_in;
  logic              rob_en_out;
  logic [OP_W-1:0]   rob_op_out;
  logic [REG_W-1:0]  rob_dest_out;
  logic [ADDR_W-1:0] rob_pc_out;
  logic              rob_taken_out;

  // Reservation station
  logic              rs_full_in;
  logic              rs_en_out;
  logic [ID_W-1:0]   rs_vj_out;
  logic [ID_W-1:0]   rs_vk_out;
  logic [ROB_W-1:0]  rs_qj_out;
  logic [ROB_W-1:0]  rs_qk_out;
  logic [ID_W-1:0]   rs_a_out;
  logic [ROB_W-1:0]  rs_dest_out;
  logic [ADDR_W-1:0] rs_pc_out;

  // Common data bus
  logic              cdb_valid_in;
  logic [ROB_W-1:0]  cdb_tag_in;
  logic [ID_W-1:0]   cdb_val_in;

  modport slave (
    input  rdy_in, clear_in,
    input  dec_valid_in, dec_rs_in, dec_rt_in, dec_rd_in, dec_imm_in, dec_op_in, dec_pc_in,
    input  dec_taken_in,
    output dec_ready_out,
    output rf_rs_out, rf_rt_out, rf_rd_en_out, rf_rd_out, rf_tag_out,
    input  rf_rs_busy_in, rf_rt_busy_in, rf_rs_val_in, rf_rt_val_in, rf_rs_tag_in, rf_rt_tag_in,
    output rob_rs_h_out, rob_rt_h_out, rob_en_out, rob_op_out, rob_dest_out, rob_pc_out,
    output rob_taken_out,
    input  rob_rs_ready_in, rob_rt_ready_in, rob_rs_val_in, rob_rt_val_in, rob_full_in, rob_b_in,
    input  rs_full_in,
    output rs_en_out, rs_vj_out, rs_vk_out, rs_qj_out, rs_qk_out, rs_a_out, rs_dest_out, rs_pc_out,
    input  cdb_valid_in, cdb_tag_in, cdb_val_in
  );

  modport master (
    output rdy_in, clear_in,
    output dec_valid_in, dec_rs_in, dec_rt_in, dec_rd_in, dec_imm_in, dec_op_in, dec_pc_in,
    output dec_taken_in,
    input  dec_ready_out,
    input  rf_rs_out, rf_rt_out, rf_rd_en_out, rf_rd_out, rf_tag_out,
    output rf_rs_busy_in, rf_rt_busy_in, rf_rs_val_in, rf_rt_val_in, rf_rs_tag_in, rf_rt_tag_in,
    input  rob_rs_h_out, rob_rt_h_out, rob_en_out, rob_op_out, rob_dest_out, rob_pc_out,
    input  rob_taken_out,
    output rob_rs_ready_in, rob_rt_ready_in, rob_rs_val_in, rob_rt_val_in, rob_full_in, rob_b_in,
    output rs_full_in,
    input  rs_en_out, rs_vj_out, rs_vk_out, rs_qj_out, rs_qk_out, rs_a_out, rs_dest_out, rs_pc_out,
    output cdb_valid_in, cdb_tag_in, cdb_val_in
  );

endinterface

// File: rtl/dispatch_fifo.sv
// Circular buffer of DEPTH entries of WIDTH bits (DEPTH a power of two, >= 2).
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        empty the buffer at the next edge (wins over push/pop)
//   push_i/wdata_i append an entry (ignored when full)
//   pop_i          drop the head entry (ignored when empty)
//   rdata_o        head entry, valid while !empty_o
//   count_o        occupancy, 0..DEPTH
//   full_o/empty_o occupancy flags
module dispatch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !clear_i;
  assign do_pop  = pop_i && !empty_o && !clear_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dispatch_stage.sv
// Buffered dispatch stage between decoder and RS/ROB/regfile.
// Decoded instructions are queued in a DEPTH-entry FIFO; the head issues when RS and ROB both have
// room. At issue, source operands are resolved from the regfile, the ROB, the rename issued in the
// previous cycle, or (optionally) the CDB, and rd is renamed to the ROB tag offered on rob_b_in.
// Ports:
//   clk_in  clock
//   rst_in  synchronous active-high reset: empties the FIFO, zeroes all registered outputs
//   bus     dispatch_stage_if.slave: decoder, regfile, ROB, RS and CDB signals
// Configuration macro:
//   DISPATCH_CDB_BYPASS_EN  when defined, an operand still waiting on tag T at issue takes the CDB
//                           value if T is broadcast in that same cycle. Otherwise cdb_* is ignored.
// Interface parameters must match the parameters of this module.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = DEF_ID_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned REG_W  = DEF_REG_W,
  parameter int unsigned ROB_W  = DEF_ROB_W,
  parameter int unsigned OP_W   = DEF_OP_W
) (
  input  logic            clk_in,
  input  logic            rst_in,
  dispatch_stage_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [OP_W-1:0]  OP_NOP_W   = OP_W'(OP_NOP);
  localparam logic [ROB_W-1:0] TAG_NONE_W = ROB_W'(ROB_TAG_NONE);

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [ID_W-1:0]   imm;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic              taken;
  } dispatch_entry_t;

  typedef struct packed {
    logic [ID_W-1:0]  v;
    logic [ROB_W-1:0] q;
  } operand_t;

  // Priority: x0, then last cycle's rename (regfile has not seen it yet), then regfile, then ROB.
  function automatic operand_t resolve_operand(
    input logic [REG_W-1:0] src,
    input logic             fwd_hit,
    input logic [ROB_W-1:0] fwd_tag,
    input logic             busy,
    input logic [ID_W-1:0]  rf_val,
    input logic [ROB_W-1:0] rf_tag,
    input logic             rob_ready,
    input logic [ID_W-1:0]  rob_val
  );
    operand_t res;
    res.v = '0;
    res.q = TAG_NONE_W;
    if (src != '0) begin
      if (fwd_hit) begin
        res.q = fwd_tag;
      end else if (!busy) begin
        res.v = rf_val;
      end else if (rob_ready) begin
        res.v = rob_val;
      end else begin
        res.q = rf_tag;
      end
    end
    return res;
  endfunction

  dispatch_entry_t head, incoming;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             unused_fifo_full;
  logic             push, pop, flush;
  operand_t         opj, opk;
  logic             fwd_j, fwd_k;

  // Registered issue outputs; rf_rd_*_q also serve as the one-cycle rename forward register.
  logic              issue_q, issue_d;
  logic              rf_rd_en_q, rf_rd_en_d;
  logic [ID_W-1:0]   vj_q, vj_d, vk_q, vk_d, a_q, a_d;
  logic [ROB_W-1:0]  qj_q, qj_d, qk_q, qk_d, tag_q, tag_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              taken_q, taken_d;

  assign incoming = '{
    rs:    bus.dec_rs_in,
    rt:    bus.dec_rt_in,
    rd:    bus.dec_rd_in,
    imm:   bus.dec_imm_in,
    op:    bus.dec_op_in,
    pc:    bus.dec_pc_in,
    taken: bus.dec_taken_in
  };

  // Ready depends only on occupancy so there is no path from RS/ROB full back to the decoder.
  assign bus.dec_ready_out = (count < CNT_W'(DEPTH));

  assign flush = bus.rdy_in && bus.clear_in;
  // NOPs are acknowledged to the decoder but never stored.
  assign push  = bus.rdy_in && !bus.clear_in && bus.dec_valid_in && bus.dec_ready_out &&
                 (bus.dec_op_in != OP_NOP_W);
  assign pop   = bus.rdy_in && !bus.clear_in && !fifo_empty && !bus.rs_full_in &&
                 !bus.rob_full_in;

  dispatch_fifo #(
    .WIDTH ($bits(dispatch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .clear_i (flush),
    .push_i  (push),
    .wdata_i (incoming),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (unused_fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.rf_rs_out    = head.rs;
  assign bus.rf_rt_out    = head.rt;
  assign bus.rob_rs_h_out = bus.rf_rs_tag_in;
  assign bus.rob_rt_h_out = bus.rf_rt_tag_in;

  assign fwd_j = rf_rd_en_q && (rf_rd_q_eq(head.rs));
  assign fwd_k = rf_rd_en_q && (rf_rd_q_eq(head.rt));

  function automatic logic rf_rd_q_eq(input logic [REG_W-1:0] src);
    return rd_q == src;
  endfunction

`ifdef DISPATCH_CDB_BYPASS_EN
  always_comb begin
    opj = resolve_operand(head.rs, fwd_j, tag_q, bus.rf_rs_busy_in, bus.rf_rs_val_in,
                          bus.rf_rs_tag_in, bus.rob_rs_ready_in, bus.rob_rs_val_in);
    opk = resolve_operand(head.rt, fwd_k, tag_q, bus.rf_rt_busy_in, bus.rf_rt_val_in,
                          bus.rf_rt_tag_in, bus.rob_rt_ready_in, bus.rob_rt_val_in);
    // Result broadcast in the issue cycle would otherwise be missed by the RS.
    if (bus.cdb_valid_in && (opj.q != TAG_NONE_W) && (opj.q == bus.cdb_tag_in)) begin
      opj.v = bus.cdb_val_in;
      opj.q = TAG_NONE_W;
    end
    if (bus.cdb_valid_in && (opk.q != TAG_NONE_W) && (opk.q == bus.cdb_tag_in)) begin
      opk.v = bus.cdb_val_in;
      opk.q = TAG_NONE_W;
    end
  end
`else
  always_comb begin
    opj = resolve_operand(head.rs, fwd_j, tag_q, bus.rf_rs_busy_in, bus.rf_rs_val_in,
                          bus.rf_rs_tag_in, bus.rob_rs_ready_in, bus.rob_rs_val_in);
    opk = resolve_operand(head.rt, fwd_k, tag_q, bus.rf_rt_busy_in, bus.rf_rt_val_in,
                          bus.rf_rt_tag_in, bus.rob_rt_ready_in, bus.rob_rt_val_in);
  end

  logic unused_cdb;
  assign unused_cdb = ^{bus.cdb_valid_in, bus.cdb_tag_in, bus.cdb_val_in};
`endif

  // pop is already low on stall or flush, so enables drop and data registers hold.
  always_comb begin
    issue_d    = pop;
    rf_rd_en_d = pop && (head.rd != '0);
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    a_d        = a_q;
    tag_d      = tag_q;
    pc_d       = pc_q;
    op_d       = op_q;
    rd_d       = rd_q;
    taken_d    = taken_q;
    if (pop) begin
      vj_d    = opj.v;
      qj_d    = opj.q;
      vk_d    = opk.v;
      qk_d    = opk.q;
      a_d     = head.imm;
      tag_d   = bus.rob_b_in;
      pc_d    = head.pc;
      op_d    = head.op;
      rd_d    = head.rd;
      taken_d = head.taken;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      issue_q    <= 1'b0;
      rf_rd_en_q <= 1'b0;
      vj_q       <= '0;
      vk_q       <= '0;
      qj_q       <= '0;
      qk_q       <= '0;
      a_q        <= '0;
      tag_q      <= '0;
      pc_q       <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      taken_q    <= 1'b0;
    end else begin
      issue_q    <= issue_d;
      rf_rd_en_q <= rf_rd_en_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      a_q        <= a_d;
      tag_q      <= tag_d;
      pc_q       <= pc_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      taken_q    <= taken_d;
    end
  end

  assign bus.rs_en_out     = issue_q;
  assign bus.rob_en_out    = issue_q;
  assign bus.rf_rd_en_out  = rf_rd_en_q;
  assign bus.rf_rd_out     = rd_q;
  assign bus.rf_tag_out    = tag_q;
  assign bus.rs_vj_out     = vj_q;
  assign bus.rs_vk_out     = vk_q;
  assign bus.rs_qj_out     = qj_q;
  assign bus.rs_qk_out     = qk_q;
  assign bus.rs_a_out      = a_q;
  assign bus.rs_dest_out   = tag_q;
  assign bus.rs_pc_out     = pc_q;
  assign bus.rob_op_out    = op_q;
  assign bus.rob_dest_out  = rd_q;
  assign bus.rob_pc_out    = pc_q;
  assign bus.rob_taken_out = taken_q;

endmodule
